// File: rtl/spi_byte_sequencer.sv
// Host-side SPI byte engine: TX FIFO -> one-byte-at-a-time SPI master handshake -> RX FIFO.
`timescale 1ns/1ps
module spi_byte_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          tx_wr,
  input  logic [7:0]    tx_data,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  input  logic          rx_rd,
  output logic [7:0]    rx_data,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  input  logic          err_clr,
  output logic          tx_ovf,
  output logic          rx_udf,
  output logic          busy,
  output logic [15:0]   xfer_count,
  output logic          spi_start,
  output logic [7:0]    spi_data_in,
  input  logic          spi_ready,
  input  logic          spi_done,
  input  logic [7:0]    spi_data_out
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  state_t state, state_nxt;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic          tx_push, tx_pop, rx_push, rx_pop, launch_ok;

  assign tx_full  = (tx_level == FULL_LVL);
  assign rx_empty = (rx_level == '0);
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp];

  // A done cycle still reports ready, so launching then would race the master.
  assign launch_ok = enable && (tx_level != '0) && spi_ready && !spi_done
                     && (rx_level < FULL_LVL);

  assign tx_push = tx_wr && !tx_full;
  assign rx_pop  = rx_rd && !rx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
    if (rx_push) rx_mem[rx_wp] <= spi_data_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_level    <= '0;
      rx_wp       <= '0;
      rx_rp       <= '0;
      rx_level    <= '0;
      spi_data_in <= '0;
      xfer_count  <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) begin
        tx_rp       <= tx_rp + AW'(1);
        spi_data_in <= tx_mem[tx_rp];
      end
      tx_level <= tx_level + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_push) begin
        rx_wp      <= rx_wp + AW'(1);
        xfer_count <= xfer_count + 16'd1;
      end
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      rx_level <= rx_level + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else if (err_clr) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (tx_wr && tx_full)  tx_ovf <= 1'b1;
      if (rx_rd && rx_empty) rx_udf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch_ok) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (spi_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_start = (state == LAUNCH);
    busy      = (state != IDLE);
    tx_pop    = (state == IDLE) && launch_ok;
    rx_push   = (state == WAIT) && spi_done;
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Scoreboard bench for spi_byte_sequencer with a loopback SPI master model.
`timescale 1ns/1ps
module tb_spi_byte_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned XFER  = 4;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, tx_wr = 1'b0, rx_rd = 1'b0, err_clr = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_full, rx_empty, tx_ovf, rx_udf, busy, spi_start;
  logic [AW:0] tx_level, rx_level;
  logic [7:0] rx_data, spi_data_in, spi_data_out, m_data, mon_e;
  logic [15:0] xfer_count;
  logic spi_done, spi_ready, m_busy, m_done, inj_done = 1'b0;
  logic [2:0] m_cnt;

  int unsigned n_chk = 0, n_pass = 0, cyc = 0, done_cyc = 0;
  bit seen_done = 0, gap_chk = 0;
  int mdl_tx = 0;
  logic [7:0] tx_q[$], rx_q[$];

  always #5 clk = ~clk;

  assign spi_done  = m_done | inj_done;
  assign spi_ready = !m_busy;

  spi_byte_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_full(tx_full), .tx_level(tx_level), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_level(rx_level), .err_clr(err_clr), .tx_ovf(tx_ovf),
    .rx_udf(rx_udf), .busy(busy), .xfer_count(xfer_count), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_ready(spi_ready), .spi_done(spi_done),
    .spi_data_out(spi_data_out)
  );

  // Loopback master: returns the launched byte XFER+1 cycles after the start pulse.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= '0; m_data <= '0; spi_data_out <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 3'd0) begin
          m_done <= 1'b1; spi_data_out <= m_data; m_busy <= 1'b0;
        end else m_cnt <= m_cnt - 3'd1;
      end else if (spi_start) begin
        m_busy <= 1'b1; m_cnt <= 3'(XFER); m_data <= spi_data_in;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst && spi_start) begin
      if (gap_chk && seen_done) check("start_gap", cyc - done_cyc, 32'd2);
      if (tx_q.size() == 0) check("unexpected_start", 32'(spi_start), 32'd0);
      else begin
        mon_e = tx_q.pop_front();
        check("spi_data_in", 32'(spi_data_in), 32'(mon_e));
        rx_q.push_back(mon_e);
        mdl_tx--;
      end
    end
    if (rst && spi_done && busy) begin
      done_cyc = cyc;
      seen_done = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    tx_wr = 1'b1; tx_data = d;
    if (mdl_tx < int'(DEPTH)) begin tx_q.push_back(d); mdl_tx++; end
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx(input string tag);
    logic [7:0] e;
    rx_rd = 1'b1;
    if (rx_q.size() == 0) check(tag, 32'(rx_data), 32'd0);
    else begin
      e = rx_q.pop_front();
      check(tag, 32'(rx_data), 32'(e));
    end
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic wait_xfer(input int unsigned n);
    int unsigned k = 0;
    while (xfer_count != 16'(n) && k < 200) begin tick(); k++; end
    check("xfer_count", 32'(xfer_count), 32'(n));
  endtask

  initial begin
    bit found;
    int unsigned k;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_sdi", 32'(spi_data_in), 32'd0);
    rst = 1'b1;
    tick();

    // single byte, start two cycles after the push
    enable = 1'b1;
    push(8'hA5);
    @(negedge clk); check("t1_start_early", 32'(spi_start), 32'd0);
    tick();
    @(negedge clk); check("t1_start", 32'(spi_start), 32'd1);
    wait_xfer(1);
    check("t1_rx_empty", 32'(rx_empty), 32'd0);
    pop_rx("t1_rx_data");
    check("t1_rx_empty_after", 32'(rx_empty), 32'd1);

    // overflow and error flags with launches disabled
    enable = 1'b0;
    for (int i = 1; i <= 9; i++) push(8'(i));
    check("t3_tx_level", 32'(tx_level), 32'd8);
    check("t3_tx_full", 32'(tx_full), 32'd1);
    check("t3_tx_ovf", 32'(tx_ovf), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_ovf_clr", 32'(tx_ovf), 32'd0);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    check("t3_rx_udf", 32'(rx_udf), 32'd1);
    rx_rd = 1'b1; err_clr = 1'b1; tick(); rx_rd = 1'b0; err_clr = 1'b0;
    check("t3_clr_prio", 32'(rx_udf), 32'd0);

    // back-to-back burst of the eight queued bytes
    seen_done = 0; gap_chk = 1;
    enable = 1'b1;
    wait_xfer(9);
    gap_chk = 0;
    check("t2_rx_level", 32'(rx_level), 32'd8);

    // RX full blocks the next launch until one pop
    push(8'h77);
    repeat (5) tick();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_tx_level", 32'(tx_level), 32'd1);
    pop_rx("t4_rx_data");
    found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(negedge clk);
      if (spi_start) found = 1;
      else tick();
    end
    check("t4_launch", 32'(found), 32'd1);
    wait_xfer(10);
    for (int i = 0; i < 8; i++) pop_rx("t4_drain");
    check("t4_rx_empty", 32'(rx_empty), 32'd1);

    // ready and done together must not launch
    enable = 1'b0;
    push(8'h5A);
    enable = 1'b1; inj_done = 1'b1;
    @(negedge clk); check("t5_start_c0", 32'(spi_start), 32'd0);
    tick(); inj_done = 1'b0;
    @(negedge clk); check("t5_start_c1", 32'(spi_start), 32'd0);
    tick();
    @(negedge clk); check("t5_start_c2", 32'(spi_start), 32'd1);
    wait_xfer(11);
    pop_rx("t5_rx_data");

    // reset while waiting on the master
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    push(8'hC3);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (busy && !spi_start) break;
      tick(); k++;
    end
    check("t6_in_wait", 32'(busy && !spi_start), 32'd1);
    rst = 1'b0;
    tx_q.delete(); rx_q.delete(); mdl_tx = 0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_start", 32'(spi_start), 32'd0);
    check("t6_sdi", 32'(spi_data_in), 32'd0);
    check("t6_xfer", 32'(xfer_count), 32'd0);
    check("t6_tx_level", 32'(tx_level), 32'd0);
    check("t6_rx_level", 32'(rx_level), 32'd0);
    check("t6_rx_data", 32'(rx_data), 32'd0);
    check("t6_rx_udf", 32'(rx_udf), 32'd0);
    check("t6_tx_ovf", 32'(tx_ovf), 32'd0);
    tick(); rst = 1'b1; tick();
    push(8'h3C);
    wait_xfer(1);
    pop_rx("t6_rx_data_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
